inst_fetch: RTL and testbench

//  Fetch stage directly downstream of the PC register. Takes the current fetch address and its exception word,

---
 rtl/inst_fetch.sv | 146 ++++++++++++++
 tb/tb_inst_fetch.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues one SRAM-style read per PC and loads the IF/ID register.
// A one-entry skid buffer holds the returned word while ID is stalled.
module inst_fetch #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] excp_in,
    input  logic              flush,
    input  logic              id_stall,
    output logic              stall_req,
    output logic              ibus_req,
    output logic [ADDR_W-1:0] ibus_addr,
    input  logic              ibus_addr_ok,
    input  logic              ibus_data_ok,
    input  logic [DATA_W-1:0] ibus_rdata,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst,
    output logic [DATA_W-1:0] id_excp
);

    typedef enum logic [2:0] {
        StBoot,
        StIdle,
        StReq,
        StWait,
        StDrop,
        StHold
    } state_e;

    state_e            state_q, state_d;
    logic              drop_q, drop_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              load;
    logic [DATA_W-1:0] load_inst;
    logic              has_excp;

    assign has_excp  = |excp_in;
    assign ibus_addr = pc;

    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        skid_d    = skid_q;
        load      = 1'b0;
        load_inst = ibus_rdata;
        ibus_req  = 1'b0;
        case (state_q)
            StBoot: state_d = StIdle;
            StIdle: begin
                if (!flush) begin
                    if (has_excp) begin
                        // Faulting address: skip the bus and deliver a NOP carrying the exception.
                        if (!id_stall) begin
                            load      = 1'b1;
                            load_inst = NOP_INST;
                        end
                    end else begin
                        ibus_req = 1'b1;
                        state_d  = ibus_addr_ok ? StWait : StReq;
                    end
                end
            end
            StReq: begin
                // Request stays up until accepted; a flush only marks the response for discard.
                ibus_req = 1'b1;
                if (flush) drop_d = 1'b1;
                if (ibus_addr_ok) state_d = (drop_q || flush) ? StDrop : StWait;
            end
            StWait: begin
                if (ibus_data_ok) begin
                    if (flush) begin
                        state_d = StIdle;
                    end else if (id_stall) begin
                        skid_d  = ibus_rdata;
                        state_d = StHold;
                    end else begin
                        load    = 1'b1;
                        state_d = StIdle;
                    end
                end else if (flush) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (ibus_data_ok) begin
                    drop_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            StHold: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (!id_stall) begin
                    load      = 1'b1;
                    load_inst = skid_q;
                    state_d   = StIdle;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    // Independent of the PC enable, so no combinational loop through the PC stage.
    assign stall_req = (state_q != StBoot) && !load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StBoot;
            drop_q  <= 1'b0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            skid_q  <= skid_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_inst  <= '0;
            id_excp  <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_inst  <= '0;
            id_excp  <= '0;
        end else if (!id_stall) begin
            if (load) begin
                id_valid <= 1'b1;
                id_pc    <= pc;
                id_inst  <= load_inst;
                id_excp  <= excp_in;
            end else begin
                id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: transaction-level model checked every cycle plus literal checkpoints.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] excp_in;
    logic        flush;
    logic        id_stall;
    logic        stall_req;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_addr_ok;
    logic        ibus_data_ok;
    logic [31:0] ibus_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [31:0] id_excp;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] Nop = 32'h0;

    inst_fetch #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .NOP_INST(Nop)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .excp_in     (excp_in),
        .flush       (flush),
        .id_stall    (id_stall),
        .stall_req   (stall_req),
        .ibus_req    (ibus_req),
        .ibus_addr   (ibus_addr),
        .ibus_addr_ok(ibus_addr_ok),
        .ibus_data_ok(ibus_data_ok),
        .ibus_rdata  (ibus_rdata),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .id_excp     (id_excp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: bus-transaction flags rather than a state encoding.
    logic        m_boot, m_pend, m_fly, m_doom, m_skid;
    logic [31:0] m_skid_data;
    logic        m_valid;
    logic [31:0] m_pc, m_inst, m_excp;
    logic        e_idle, e_req, e_load, e_stall;
    logic [31:0] e_inst;

    always @(negedge clk) begin
        if (rst) begin
            m_boot = 1'b1; m_pend = 1'b0; m_fly = 1'b0; m_doom = 1'b0; m_skid = 1'b0;
            m_skid_data = '0;
            m_valid = 1'b0; m_pc = '0; m_inst = '0; m_excp = '0;
            chk("rst_valid", id_valid, 0);
            chk("rst_inst", id_inst, 0);
        end else begin
            e_idle = !m_boot && !m_pend && !m_fly && !m_skid;
            e_req  = m_pend || (e_idle && !flush && excp_in == 0);
            e_load = 1'b0;
            e_inst = '0;
            if (e_idle && !flush && excp_in != 0 && !id_stall) begin
                e_load = 1'b1; e_inst = Nop;
            end
            if (m_fly && !m_doom && ibus_data_ok && !flush && !id_stall) begin
                e_load = 1'b1; e_inst = ibus_rdata;
            end
            if (m_skid && !flush && !id_stall) begin
                e_load = 1'b1; e_inst = m_skid_data;
            end
            e_stall = !m_boot && !e_load;

            chk("m_ibus_req", ibus_req, e_req);
            chk("m_stall_req", stall_req, e_stall);
            if (e_req) chk("m_ibus_addr", ibus_addr, pc);
            chk("m_id_valid", id_valid, m_valid);
            chk("m_id_pc", id_pc, m_pc);
            chk("m_id_inst", id_inst, m_inst);
            chk("m_id_excp", id_excp, m_excp);

            if (flush) begin
                m_valid = 1'b0; m_pc = '0; m_inst = '0; m_excp = '0;
            end else if (!id_stall) begin
                if (e_load) begin
                    m_valid = 1'b1; m_pc = pc; m_inst = e_inst; m_excp = excp_in;
                end else begin
                    m_valid = 1'b0;
                end
            end

            if (m_boot) begin
                m_boot = 1'b0;
            end else if (m_pend) begin
                if (flush) m_doom = 1'b1;
                if (ibus_addr_ok) begin
                    m_pend = 1'b0; m_fly = 1'b1;
                end
            end else if (e_idle) begin
                if (e_req) begin
                    m_doom = 1'b0;
                    if (ibus_addr_ok) m_fly = 1'b1;
                    else m_pend = 1'b1;
                end
            end else if (m_fly) begin
                if (ibus_data_ok) begin
                    m_fly = 1'b0;
                    if (!m_doom && !flush && id_stall) begin
                        m_skid = 1'b1; m_skid_data = ibus_rdata;
                    end
                    m_doom = 1'b0;
                end else if (flush) begin
                    m_doom = 1'b1;
                end
            end else if (m_skid) begin
                if (flush || !id_stall) m_skid = 1'b0;
            end
        end
    end

    task automatic set(input logic [31:0] p, input logic [31:0] ex, input logic fl,
                       input logic st, input logic aok, input logic dok, input logic [31:0] rd);
        pc = p; excp_in = ex; flush = fl; id_stall = st;
        ibus_addr_ok = aok; ibus_data_ok = dok; ibus_rdata = rd;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; pc = 32'hBFC0_0000; excp_in = '0; flush = 1'b0; id_stall = 1'b0;
        ibus_addr_ok = 1'b0; ibus_data_ok = 1'b0; ibus_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_id_valid", id_valid, 0);
        chk("reset_id_pc", id_pc, 0);
        rst = 1'b0;

        // Boot cycle
        set(32'hBFC0_0000, 0, 0, 0, 0, 0, 0);
        chk("boot_stall", stall_req, 0);
        chk("boot_req", ibus_req, 0);
        tick();

        // 1: zero-wait fetch
        set(32'hBFC0_0000, 0, 0, 0, 1, 0, 0);
        chk("t1_req", ibus_req, 1);
        chk("t1_addr", ibus_addr, 32'hBFC0_0000);
        tick();
        set(32'hBFC0_0000, 0, 0, 0, 0, 1, 32'h2408_0001);
        chk("t1_stall_low", stall_req, 0);
        tick();
        chk("t1_valid", id_valid, 1);
        chk("t1_pc", id_pc, 32'hBFC0_0000);
        chk("t1_inst", id_inst, 32'h2408_0001);

        // 2: addr_ok delayed three cycles
        for (int i = 0; i < 3; i++) begin
            set(32'hBFC0_0004, 0, 0, 0, 0, 0, 0);
            chk("t2_req_held", ibus_req, 1);
            chk("t2_addr_stable", ibus_addr, 32'hBFC0_0004);
            chk("t2_stall", stall_req, 1);
            tick();
        end
        set(32'hBFC0_0004, 0, 0, 0, 1, 0, 0);
        chk("t2_req_accept", ibus_req, 1);
        chk("t2_stall_accept", stall_req, 1);
        tick();
        set(32'hBFC0_0004, 0, 0, 0, 0, 1, 32'h0000_0013);
        tick();
        chk("t2_inst", id_inst, 32'h0000_0013);

        // 3: flush while waiting for data
        set(32'hBFC0_0008, 0, 0, 0, 1, 0, 0);
        tick();
        set(32'hBFC0_0008, 0, 1, 0, 0, 0, 0);
        tick();
        chk("t3_flushed_valid", id_valid, 0);
        set(32'h8000_0000, 0, 0, 0, 0, 0, 0);
        chk("t3_drop_no_req", ibus_req, 0);
        tick();
        set(32'h8000_0000, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        tick();
        chk("t3_discard_valid", id_valid, 0);
        chk("t3_discard_inst", id_inst, 0);
        set(32'h8000_0000, 0, 0, 0, 1, 0, 0);
        chk("t3_new_req", ibus_req, 1);
        chk("t3_new_addr", ibus_addr, 32'h8000_0000);
        tick();
        set(32'h8000_0000, 0, 0, 0, 0, 1, 32'h1111_1111);
        tick();
        chk("t3_next_inst", id_inst, 32'h1111_1111);

        // 4: ID stalled when data returns
        set(32'h8000_0004, 0, 0, 0, 1, 0, 0);
        tick();
        set(32'h8000_0004, 0, 0, 1, 0, 1, 32'h8C82_0004);
        chk("t4_stall_on_data", stall_req, 1);
        tick();
        chk("t4_not_loaded", id_inst, 32'h1111_1111);
        for (int i = 0; i < 2; i++) begin
            set(32'h8000_0004, 0, 0, 1, 0, 0, 0);
            chk("t4_hold_no_req", ibus_req, 0);
            chk("t4_hold_stall", stall_req, 1);
            tick();
        end
        set(32'h8000_0004, 0, 0, 0, 0, 0, 0);
        chk("t4_release_stall", stall_req, 0);
        tick();
        chk("t4_inst", id_inst, 32'h8C82_0004);
        chk("t4_pc", id_pc, 32'h8000_0004);

        // 5: address-error exception
        set(32'hBFC0_0002, 32'h10, 0, 1, 0, 0, 0);
        chk("t5_stalled_no_req", ibus_req, 0);
        chk("t5_stalled_stall", stall_req, 1);
        tick();
        set(32'hBFC0_0002, 32'h10, 0, 0, 0, 0, 0);
        chk("t5_no_req", ibus_req, 0);
        chk("t5_stall_low", stall_req, 0);
        tick();
        chk("t5_valid", id_valid, 1);
        chk("t5_inst", id_inst, Nop);
        chk("t5_excp", id_excp, 32'h10);
        chk("t5_pc", id_pc, 32'hBFC0_0002);

        // 6: flush while request is still pending
        set(32'h8000_0008, 0, 0, 0, 0, 0, 0);
        tick();
        set(32'h8000_0008, 0, 1, 0, 0, 0, 0);
        chk("t6_req_kept", ibus_req, 1);
        tick();
        set(32'h8000_1000, 0, 0, 0, 1, 0, 0);
        chk("t6_req_until_ok", ibus_req, 1);
        tick();
        set(32'h8000_1000, 0, 0, 0, 0, 0, 0);
        chk("t6_drop_no_req", ibus_req, 0);
        tick();
        set(32'h8000_1000, 0, 0, 0, 0, 1, 32'hBAD0_BAD0);
        tick();
        chk("t6_valid", id_valid, 0);
        chk("t6_inst", id_inst, 0);

        // Flush coincident with data_ok
        set(32'h8000_1000, 0, 0, 0, 1, 0, 0);
        chk("t7_addr", ibus_addr, 32'h8000_1000);
        tick();
        set(32'h8000_1000, 0, 1, 0, 0, 1, 32'hCAFE_F00D);
        tick();
        chk("t7_discard", id_valid, 0);
        set(32'h8000_2000, 0, 0, 0, 1, 0, 0);
        tick();
        set(32'h8000_2000, 0, 0, 0, 0, 1, 32'h1234_5678);
        tick();
        chk("t7_inst", id_inst, 32'h1234_5678);

        // Reset during an outstanding read
        set(32'h8000_2004, 0, 0, 0, 1, 0, 0);
        tick();
        rst = 1'b1;
        #2;
        chk("t8_async_clear", id_valid, 0);
        tick();
        rst = 1'b0;
        set(32'h8000_2004, 0, 0, 0, 0, 0, 0);
        chk("t8_boot_stall", stall_req, 0);
        tick();
        set(32'h8000_2004, 0, 0, 0, 1, 0, 0);
        tick();
        set(32'h8000_2004, 0, 0, 0, 0, 1, 32'hA5A5_A5A5);
        tick();
        chk("t8_inst", id_inst, 32'hA5A5_A5A5);
        set(32'h8000_2008, 0, 0, 1, 0, 0, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
